// File: rtl/mips_multicycle_ctrl.sv
// Main-decoder FSM for a shared-memory multicycle MIPS datapath.
// Control outputs decode combinationally from the current state; memory states wait on mready_i.
module mips_multicycle_ctrl #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mready_i,
    output logic       pcen_o,
    output logic       irwrite_o,
    output logic       iord_o,
    output logic       memread_o,
    output logic       memwrite_o,
    output logic       regwrite_o,
    output logic       memtoreg_o,
    output logic       regdst_o,
    output logic       link_o,
    output logic       byteld_o,
    output logic       lbu_o,
    output logic       alusrca_o,
    output logic [2:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [3:0] alucontrol_o,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StImmEx  = 4'd9,
        StImmWb  = 4'd10,
        StJump   = 4'd11,
        StJr     = 4'd12,
        StJal    = 4'd13
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLb    = 6'b100000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpLbu   = 6'b100100;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnJr    = 6'b001000;

    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluSub  = 4'b0110;
    localparam logic [3:0] AluSlt  = 4'b0111;
    localparam logic [3:0] AluNor  = 4'b1100;

    state_e state_q, state_d;

    logic       is_load, is_store, is_byte;
    logic       funct_ok;
    logic [3:0] funct_alu;

    always_comb begin
        is_load  = (op_i == OpLw) || (op_i == OpLb) || (op_i == OpLbu);
        is_store = (op_i == OpSw);
        is_byte  = (op_i == OpLb) || (op_i == OpLbu);
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = AluAdd;
        case (funct_i)
            6'b100000: funct_alu = AluAdd;
            6'b100010: funct_alu = AluSub;
            6'b100100: funct_alu = AluAnd;
            6'b100101: funct_alu = AluOr;
            6'b101010: funct_alu = AluSlt;
            6'b100111: funct_alu = AluNor;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pcen_o       = 1'b0;
        irwrite_o    = 1'b0;
        iord_o       = 1'b0;
        memread_o    = 1'b0;
        memwrite_o   = 1'b0;
        regwrite_o   = 1'b0;
        memtoreg_o   = 1'b0;
        regdst_o     = 1'b0;
        link_o       = 1'b0;
        byteld_o     = 1'b0;
        lbu_o        = 1'b0;
        alusrca_o    = 1'b0;
        alusrcb_o    = 3'b000;
        pcsrc_o      = 2'b00;
        alucontrol_o = AluAdd;
        illegal_o    = 1'b0;

        case (state_q)
            StFetch: begin
                memread_o = 1'b1;
                alusrcb_o = 3'b001;
                irwrite_o = mready_i;
                pcen_o    = mready_i;
                if (mready_i) state_d = StDecode;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut while the opcode is decoded.
                alusrcb_o = 3'b011;
                if (is_load || is_store) begin
                    state_d = StMemAdr;
                end else if (op_i == OpRType) begin
                    state_d = (funct_i == FnJr) ? StJr : StExec;
                end else if (op_i == OpBeq || op_i == OpBne) begin
                    state_d = StBranch;
                end else if (op_i == OpAddi || op_i == OpSlti ||
                             op_i == OpAndi || op_i == OpOri) begin
                    state_d = StImmEx;
                end else if (op_i == OpJ) begin
                    state_d = StJump;
                end else if (op_i == OpJal) begin
                    state_d = StJal;
                end else begin
                    illegal_o = 1'b1;
                    state_d   = StFetch;
                end
            end
            StMemAdr: begin
                alusrca_o = 1'b1;
                alusrcb_o = 3'b010;
                state_d   = is_store ? StMemWr : StMemRd;
            end
            StMemRd: begin
                memread_o = 1'b1;
                iord_o    = 1'b1;
                byteld_o  = is_byte;
                lbu_o     = (op_i == OpLbu);
                if (mready_i) state_d = StMemWb;
            end
            StMemWb: begin
                regwrite_o = 1'b1;
                memtoreg_o = 1'b1;
                byteld_o   = is_byte;
                lbu_o      = (op_i == OpLbu);
                state_d    = StFetch;
            end
            StMemWr: begin
                memwrite_o = 1'b1;
                iord_o     = 1'b1;
                if (mready_i) state_d = StFetch;
            end
            StExec: begin
                alusrca_o = 1'b1;
                if (funct_ok) begin
                    alucontrol_o = funct_alu;
                    state_d      = StAluWb;
                end else begin
                    illegal_o = 1'b1;
                    state_d   = StFetch;
                end
            end
            StAluWb: begin
                regwrite_o = 1'b1;
                regdst_o   = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alusrca_o    = 1'b1;
                alucontrol_o = AluSub;
                pcsrc_o      = 2'b01;
                pcen_o       = (op_i == OpBne) ? ~zero_i : zero_i;
                state_d      = StFetch;
            end
            StImmEx: begin
                alusrca_o = 1'b1;
                case (op_i)
                    OpSlti: begin
                        alusrcb_o    = 3'b010;
                        alucontrol_o = AluSlt;
                    end
                    OpAndi: begin
                        alusrcb_o    = 3'b100;
                        alucontrol_o = AluAnd;
                    end
                    OpOri: begin
                        alusrcb_o    = 3'b100;
                        alucontrol_o = AluOr;
                    end
                    default: alusrcb_o = 3'b010;
                endcase
                state_d = StImmWb;
            end
            StImmWb: begin
                regwrite_o = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                pcsrc_o = 2'b10;
                pcen_o  = 1'b1;
                state_d = StFetch;
            end
            StJr: begin
                pcsrc_o = 2'b11;
                pcen_o  = 1'b1;
                state_d = StFetch;
            end
            StJal: begin
                // Writes PC+4 to the return-address register (RA_REG) in the datapath.
                regwrite_o = 1'b1;
                link_o     = 1'b1;
                pcsrc_o    = 2'b10;
                pcen_o     = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main-decoder FSM that sequences a shared-memory multicycle MIPS datapath: one ALU and one memory port, reused across fetch, decode, execute, memory and writeback steps.
Supports R-type (add/sub/and/or/slt/nor/jr), lw/lb/lbu/sw, beq/bne, addi/slti/andi/ori, and j/jal.
Holds in memory states until the memory returns ready.

Parameters:
RA_REG, 5'd31, destination register written by jal (datapath uses it when link=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mready  in  1  memory done/ready for the current access
pcen  out  1  PC register enable
irwrite  out  1  instruction register load
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memread  out  1  memory read request
memwrite  out  1  memory write request
regwrite  out  1  register file write
memtoreg  out  1  writeback data select: 1 = memory data
regdst  out  1  destination select: 1 = rd, 0 = rt
link  out  1  write PC (already +4) to RA_REG
byteld  out  1  byte load (lb/lbu)
lbu  out  1  zero-extend byte load
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
alusrcb  out  3  ALU B select: 000 B, 001 const 4, 010 signimm, 011 signimm<<2, 100 zeroimm
pcsrc  out  2  next-PC select: 00 ALUResult, 01 ALUOut, 10 jump target, 11 register A (jr)
alucontrol  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
state  out  4  current state (debug)
illegal  out  1  one-cycle pulse in DECODE/EXEC on an unsupported op or funct

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, JR=12, JAL=13.
- Reset (asynchronous): state=FETCH. All outputs are combinational from state; with reset held, outputs are FETCH values with mready gating applied.
- Unless listed below, every strobe = 0, alusrcb=000, pcsrc=00, alucontrol=0010.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=001, ADD.
  - irwrite and pcen = mready.
  - Stay in FETCH while !mready; when mready, go to DECODE.
- DECODE:
  - alusrca=0, alusrcb=011, ADD (branch target into ALUOut).
  - lw/lb/lbu/sw → MEMADR; R-type with funct 001000 → JR; other R-type → EXEC; beq/bne → BRANCH; addi/slti/andi/ori → IMMEX; j → JUMP; jal → JAL.
  - Any other op: illegal=1, go to FETCH.
- MEMADR: alusrca=1, alusrcb=010, ADD. sw → MEMWR; loads → MEMRD.
- MEMRD:
  - memread=1, iord=1; byteld and lbu reflect op.
  - Wait for mready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, byteld/lbu per op. Go to FETCH.
- MEMWR:
  - memwrite=1, iord=1, held until mready.
  - The mready cycle is the last cycle of memwrite; then go to FETCH.
- EXEC:
  - alusrca=1, alusrcb=000.
  - funct decode: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 100111→1100.
  - Valid funct → ALUWB. Unknown funct: illegal=1, go to FETCH, no write.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
- BRANCH:
  - alusrca=1, alusrcb=000, SUB, pcsrc=01.
  - pcen = zero for beq, !zero for bne.
  - Go to FETCH.
- IMMEX:
  - alusrca=1.
  - addi: alusrcb=010, ADD. slti: alusrcb=010, SLT. andi: alusrcb=100, AND. ori: alusrcb=100, OR.
  - Go to IMMWB.
- IMMWB: regwrite=1, regdst=0. Go to FETCH.
- JUMP: pcsrc=10, pcen=1. Go to FETCH.
- JR: pcsrc=11, pcen=1. Go to FETCH.
- JAL: regwrite=1, link=1, pcsrc=10, pcen=1 in the same cycle. Go to FETCH.
- Boundary conditions:
  - mready already high on entry to a memory state: zero wait cycles.
  - Reset asserted during a wait state aborts it; memwrite drops in the same cycle.
  - Unused encodings 14–15 → FETCH next cycle, all strobes 0.
- Cycle counts with mready=1: lw 5, sw 4, R-type 4, branch 3, imm 4, j/jr/jal 3.

Test Plan:
- Reset mid-MEMWR (op=101011, mready=0) → memwrite falls without waiting for clk; state=0 after release; memwrite stays 0 while reset is held.
- lw (op=100011), mready=1 every cycle → states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; irwrite and pcen=1 only in cycle 0.
- FETCH with mready low for 3 cycles → stays in state 0; irwrite and pcen stay 0 for 3 cycles, then pulse 1 cycle; next state 1.
- bne (op=000101): zero=0 → pcen=1, pcsrc=01 in state 8; with zero=1 → pcen=0; beq gives the inverse.
- R-type funct=100111 → alucontrol=1100 in EXEC, regdst=1 in ALUWB. funct=000000 → illegal pulse, back to FETCH, regwrite never asserted.
- jal (op=000011) → state 13 for one cycle with regwrite=1, link=1, pcen=1, pcsrc=10. jr (funct=001000) → state 12 with pcsrc=11, regwrite=0.
